// File: rtl/sqrt_axis_pkg.sv
// Shared types and constants for the iterative AXI4-Stream square-root core.
package sqrt_axis_pkg;

   // Controller states: wait for input, iterate, finalise, present result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Encodings for the ROUND parameter.
   localparam int ROUND_FLOOR   = 0;
   localparam int ROUND_NEAREST = 1;

   // Width of the iteration counter for a root of res_w bits.
   // A 1-bit root still needs a 1-bit counter.
   function automatic int counter_width(input int res_w);
      return (res_w > 1) ? $clog2(res_w) : 1;
   endfunction

endpackage

// File: rtl/sqrt_iter_step.sv
// One restoring digit-by-digit square-root iteration, purely combinational.
// Consumes one 2-bit digit of the radicand and produces one root bit.
module sqrt_iter_step #(
   parameter int RES_W = 8
) (
   input  logic [RES_W+1:0] rem_i,
   input  logic [RES_W-1:0] root_i,
   input  logic [1:0]       digit_i,
   output logic [RES_W+1:0] rem_o,
   output logic [RES_W-1:0] root_o
);

   logic [RES_W+1:0] rem_sh;
   logic [RES_W+1:0] trial;

   // Bring down the next digit pair and try subtracting (4*root + 1).
   // The remainder never exceeds 2*root, so the two bits shifted out are zero.
   always_comb begin
      rem_sh = (rem_i << 2) | {{RES_W{1'b0}}, digit_i};
      trial  = {root_i, 2'b01};
      if (rem_sh >= trial) begin
         rem_o  = rem_sh - trial;
         root_o = {root_i[RES_W-2:0], 1'b1};
      end else begin
         rem_o  = rem_sh;
         root_o = {root_i[RES_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/sqrt_axis_iter.sv
// Iterative integer square root with AXI4-Stream input and output.
// One root bit per cycle; a single operation in flight; the output beat
// is held until accepted, and a new radicand may be taken on that same cycle.
module sqrt_axis_iter
   import sqrt_axis_pkg::*;
#(
   parameter  int DATA_W = 16,
   parameter  int ROUND  = ROUND_FLOOR,
   parameter  int USER_W = 1,
   localparam int RES_W  = DATA_W / 2
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic [USER_W-1:0] s_axis_tuser,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [RES_W-1:0]  m_axis_tdata,
   output logic [RES_W:0]    m_axis_trem,
   output logic [USER_W-1:0] m_axis_tuser
);

   localparam int              CNT_W    = counter_width(RES_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RES_W - 1);
   localparam bit              RND_NEAR = (ROUND == ROUND_NEAREST);

   // Reject illegal parameterisations at elaboration time.
   generate
      if ((DATA_W % 2 != 0) || (DATA_W < 4)) begin : g_bad_data_w
         $error("sqrt_axis_iter: DATA_W must be even and >= 4");
      end
      if ((ROUND != ROUND_FLOOR) && (ROUND != ROUND_NEAREST)) begin : g_bad_round
         $error("sqrt_axis_iter: ROUND must be 0 (floor) or 1 (nearest)");
      end
   endgenerate

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] x_q, x_d;
   logic [RES_W+1:0]  rem_q, rem_d;
   logic [RES_W-1:0]  root_q, root_d;
   logic [USER_W-1:0] user_q, user_d;
   logic [RES_W-1:0]  tdata_q, tdata_d;
   logic [RES_W:0]    trem_q, trem_d;
   logic [USER_W-1:0] tuser_q, tuser_d;
   logic              tvalid_q, tvalid_d;

   logic [RES_W+1:0]  step_rem;
   logic [RES_W-1:0]  step_root;
   logic [RES_W-1:0]  root_fin;
   logic              s_ready;
   logic              s_fire;
   logic              m_fire;

   // The radicand register shifts left two bits per iteration, so its top
   // pair is always the digit for the current iteration.
   sqrt_iter_step #(
      .RES_W (RES_W)
   ) u_step (
      .rem_i   (rem_q),
      .root_i  (root_q),
      .digit_i (x_q[DATA_W-1 -: 2]),
      .rem_o   (step_rem),
      .root_o  (step_root)
   );

   // Round-to-nearest: the true root is closer to r+1 exactly when rem > r.
   always_comb begin
      root_fin = root_q;
      if (RND_NEAR && (rem_q > {2'b00, root_q}) && (root_q != '1)) begin
         root_fin = root_q + 1'b1;
      end
   end

   // Next-state and datapath control for the IDLE/CALC/FIN/DONE controller.
   always_comb begin
      // NOTE: every signal driven here gets a default first so that no path
      // through the case leaves it unassigned, which would infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      x_d      = x_q;
      rem_d    = rem_q;
      root_d   = root_q;
      user_d   = user_q;
      tdata_d  = tdata_q;
      trem_d   = trem_q;
      tuser_d  = tuser_q;
      tvalid_d = tvalid_q;
      s_ready  = 1'b0;

      m_fire = tvalid_q & m_axis_tready;

      case (state_q)
         IDLE:    s_ready = 1'b1;
         DONE:    s_ready = m_axis_tready;
         default: s_ready = 1'b0;
      endcase
      s_fire = s_axis_tvalid & s_ready;

      case (state_q)
         CALC: begin
            x_d    = x_q << 2;
            rem_d  = step_rem;
            root_d = step_root;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = FIN;
            end
         end
         FIN: begin
            tdata_d  = root_fin;
            trem_d   = rem_q[RES_W:0];
            tuser_d  = user_q;
            tvalid_d = 1'b1;
            state_d  = DONE;
         end
         DONE: begin
            if (m_fire) begin
               tvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: ;
      endcase

      // Accepting a radicand (from IDLE, or overlapped with the DONE
      // handshake) always starts a fresh computation.
      if (s_fire) begin
         x_d     = s_axis_tdata;
         user_d  = s_axis_tuser;
         rem_d   = '0;
         root_d  = '0;
         cnt_d   = '0;
         state_d = CALC;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge aclk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      if (areset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         x_q      <= '0;
         rem_q    <= '0;
         root_q   <= '0;
         user_q   <= '0;
         tdata_q  <= '0;
         trem_q   <= '0;
         tuser_q  <= '0;
         tvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         x_q      <= x_d;
         rem_q    <= rem_d;
         root_q   <= root_d;
         user_q   <= user_d;
         tdata_q  <= tdata_d;
         trem_q   <= trem_d;
         tuser_q  <= tuser_d;
         tvalid_q <= tvalid_d;
      end
   end

   // Hold off input while reset is asserted.
   assign s_axis_tready = s_ready & ~areset;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_trem   = trem_q;
   assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_sqrt_axis_iter.sv
// Scoreboard bench for sqrt_axis_iter: a floor and a nearest 16-bit instance
// share one input stream; a 32-bit nearest instance has its own stream.
module tb_sqrt_axis_iter;

   logic aclk = 1'b0;
   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   logic        areset;
   logic        s_tvalid;
   logic [15:0] s_tdata;
   logic [1:0]  s_tuser;
   logic        m_tready;
   logic        c_s_tvalid;
   logic [31:0] c_s_tdata;
   logic        c_s_tuser;
   logic        c_m_tready;

   logic        a_s_tready, a_m_tvalid;
   logic [7:0]  a_m_tdata;
   logic [8:0]  a_m_trem;
   logic [1:0]  a_m_tuser;
   logic        b_s_tready, b_m_tvalid;
   logic [7:0]  b_m_tdata;
   logic [8:0]  b_m_trem;
   logic [1:0]  b_m_tuser;
   logic        c_s_tready, c_m_tvalid;
   logic [15:0] c_m_tdata;
   logic [16:0] c_m_trem;
   logic        c_m_tuser;

   sqrt_axis_iter #(.DATA_W(16), .ROUND(0), .USER_W(2)) u_a (
      .aclk(aclk), .areset(areset),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(a_s_tready),
      .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser),
      .m_axis_tvalid(a_m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tdata(a_m_tdata), .m_axis_trem(a_m_trem), .m_axis_tuser(a_m_tuser)
   );

   sqrt_axis_iter #(.DATA_W(16), .ROUND(1), .USER_W(2)) u_b (
      .aclk(aclk), .areset(areset),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(b_s_tready),
      .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser),
      .m_axis_tvalid(b_m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tdata(b_m_tdata), .m_axis_trem(b_m_trem), .m_axis_tuser(b_m_tuser)
   );

   sqrt_axis_iter #(.DATA_W(32), .ROUND(1), .USER_W(1)) u_c (
      .aclk(aclk), .areset(areset),
      .s_axis_tvalid(c_s_tvalid), .s_axis_tready(c_s_tready),
      .s_axis_tdata(c_s_tdata), .s_axis_tuser(c_s_tuser),
      .m_axis_tvalid(c_m_tvalid), .m_axis_tready(c_m_tready),
      .m_axis_tdata(c_m_tdata), .m_axis_trem(c_m_trem), .m_axis_tuser(c_m_tuser)
   );

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string tag, input longint unsigned got, input longint unsigned want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   typedef struct {
      longint unsigned root;
      longint unsigned rem;
      longint unsigned user;
      int              acc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   // Reference: exact floor root by search, nearest by comparing distances.
   function automatic exp_t model(input longint unsigned x, input int rw, input bit rnd,
                                  input longint unsigned user, input int acc);
      exp_t e;
      longint unsigned r;
      longint unsigned top;
      r = longint'($floor($sqrt(real'(x))));
      while (r * r > x) r--;
      while ((r + 1) * (r + 1) <= x) r++;
      e.rem = x - r * r;
      top = (64'd1 << rw) - 1;
      if (rnd && (((r + 1) * (r + 1) - x) < (x - r * r)) && (r < top)) r++;
      e.root = r;
      e.user = user;
      e.acc  = acc;
      return e;
   endfunction

   // Scoreboard push: an accepted beat (handshake at the coming edge).
   always @(negedge aclk) begin
      if (areset) begin
         qa.delete();
         qb.delete();
         qc.delete();
      end else begin
         if (s_tvalid && a_s_tready) qa.push_back(model(s_tdata, 8, 1'b0, s_tuser, cyc + 1));
         if (s_tvalid && b_s_tready) qb.push_back(model(s_tdata, 8, 1'b1, s_tuser, cyc + 1));
         if (c_s_tvalid && c_s_tready) qc.push_back(model(c_s_tdata, 16, 1'b1, c_s_tuser, cyc + 1));
      end
   end

   logic a_pv = 1'b0;
   logic b_pv = 1'b0;
   logic c_pv = 1'b0;

   // Output monitors: compare while valid (also covers hold stability), pop on handshake.
   always @(negedge aclk) begin
      if (!areset && a_m_tvalid) begin
         if (qa.size() == 0) check("a_unexpected_beat", 1, 0);
         else begin
            if (!a_pv) check("a_latency", longint'(cyc - qa[0].acc), 9);
            check("a_root", a_m_tdata, qa[0].root);
            check("a_rem", a_m_trem, qa[0].rem);
            check("a_user", a_m_tuser, qa[0].user);
            if (m_tready) void'(qa.pop_front());
         end
      end
      a_pv <= a_m_tvalid & ~areset;
   end

   always @(negedge aclk) begin
      if (!areset && b_m_tvalid) begin
         if (qb.size() == 0) check("b_unexpected_beat", 1, 0);
         else begin
            if (!b_pv) check("b_latency", longint'(cyc - qb[0].acc), 9);
            check("b_root", b_m_tdata, qb[0].root);
            check("b_rem", b_m_trem, qb[0].rem);
            check("b_user", b_m_tuser, qb[0].user);
            if (m_tready) void'(qb.pop_front());
         end
      end
      b_pv <= b_m_tvalid & ~areset;
   end

   always @(negedge aclk) begin
      if (!areset && c_m_tvalid) begin
         if (qc.size() == 0) check("c_unexpected_beat", 1, 0);
         else begin
            if (!c_pv) check("c_latency", longint'(cyc - qc[0].acc), 17);
            check("c_root", c_m_tdata, qc[0].root);
            check("c_rem", c_m_trem, qc[0].rem);
            check("c_user", c_m_tuser, qc[0].user);
            if (c_m_tready) void'(qc.pop_front());
         end
      end
      c_pv <= c_m_tvalid & ~areset;
   end

   task automatic send16(input logic [15:0] x, input logic [1:0] u);
      bit ok = 1'b0;
      @(posedge aclk); #1;
      s_tvalid = 1'b1;
      s_tdata  = x;
      s_tuser  = u;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge aclk);
         if (a_s_tready) ok = 1'b1;
      end
      if (!ok) check("a_accept_timeout", 0, 1);
      @(posedge aclk); #1;
      s_tvalid = 1'b0;
   endtask

   task automatic send32(input logic [31:0] x, input logic u);
      bit ok = 1'b0;
      @(posedge aclk); #1;
      c_s_tvalid = 1'b1;
      c_s_tdata  = x;
      c_s_tuser  = u;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge aclk);
         if (c_s_tready) ok = 1'b1;
      end
      if (!ok) check("c_accept_timeout", 0, 1);
      @(posedge aclk); #1;
      c_s_tvalid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         @(negedge aclk);
         if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0 &&
             !a_m_tvalid && !b_m_tvalid && !c_m_tvalid) return;
      end
      check("drain_timeout", 0, 1);
   endtask

   logic [15:0] vec16 [6] = '{16'd1024, 16'd2, 16'd1023, 16'd0, 16'd65535, 16'd21};
   logic [31:0] vec32 [4] = '{32'hFFFF_FFFF, 32'd1000000, 32'd0, 32'd4294836225};

   initial begin
      bit seen;
      areset     = 1'b1;
      s_tvalid   = 1'b0;
      s_tdata    = '0;
      s_tuser    = '0;
      m_tready   = 1'b1;
      c_s_tvalid = 1'b0;
      c_s_tdata  = '0;
      c_s_tuser  = 1'b0;
      c_m_tready = 1'b1;

      // Reset state.
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      check("rst_a_s_tready", a_s_tready, 0);
      check("rst_a_m_tvalid", a_m_tvalid, 0);
      check("rst_a_m_tdata", a_m_tdata, 0);
      check("rst_a_m_trem", a_m_trem, 0);
      check("rst_a_m_tuser", a_m_tuser, 0);
      check("rst_c_m_tvalid", c_m_tvalid, 0);
      check("rst_c_m_trem", c_m_trem, 0);
      @(posedge aclk); #1;
      areset = 1'b0;
      @(negedge aclk);
      check("post_rst_a_s_tready", a_s_tready, 1);
      check("post_rst_c_s_tready", c_s_tready, 1);

      // Basic and boundary radicands, no backpressure.
      foreach (vec16[i]) begin
         send16(vec16[i], 2'(i));
         drain();
      end

      // Backpressure on x=400 while x=9 waits with tvalid held high.
      m_tready = 1'b0;
      send16(16'd400, 2'd3);
      s_tvalid = 1'b1;
      s_tdata  = 16'd9;
      s_tuser  = 2'd1;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge aclk);
         if (a_m_tvalid) seen = 1'b1;
      end
      if (!seen) check("bp_valid_timeout", 0, 1);
      check("bp_s_tready_0", a_s_tready, 0);
      for (int i = 1; i < 5; i++) begin
         @(negedge aclk);
         check("bp_s_tready", a_s_tready, 0);
         check("bp_m_tvalid", a_m_tvalid, 1);
      end
      @(posedge aclk); #1;
      m_tready = 1'b1;
      @(negedge aclk);
      check("ovl_a_s_tready", a_s_tready, 1);
      check("ovl_b_s_tready", b_s_tready, 1);
      @(posedge aclk); #1;
      s_tvalid = 1'b0;
      drain();

      // Reset three cycles into a computation discards it.
      send16(16'd1024, 2'd2);
      repeat (2) @(posedge aclk);
      #1 areset = 1'b1;
      @(negedge aclk);
      check("mid_rst_s_tready", a_s_tready, 0);
      @(posedge aclk); #1;
      areset = 1'b0;
      @(negedge aclk);
      check("mid_rst_after_s_tready", a_s_tready, 1);
      for (int i = 0; i < 12; i++) begin
         @(negedge aclk);
         check("mid_rst_no_beat", a_m_tvalid | b_m_tvalid, 0);
      end
      send16(16'd49, 2'd1);
      drain();

      // 32-bit nearest instance, including saturation at 65535.
      foreach (vec32[i]) begin
         send32(vec32[i], 1'(i));
         drain();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
